// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, single-entry IF/ID slot, redirect flush.
// Optional misaligned-fetch fault reporting is enabled by defining FETCH_MISALIGN_ERR_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        redirect,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_err,
  input  logic        if_ready
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DROP, ERR} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        slot_valid_reg;
  logic [31:0] slot_pc_reg;
  logic [31:0] slot_instr_reg;
  logic        slot_free;
  logic        load_slot;
`ifdef FETCH_MISALIGN_ERR_EN
  logic        slot_err_reg;
  logic        load_err;
`endif

  // The slot can accept a new entry if it is empty or being consumed this cycle.
  assign slot_free = !slot_valid_reg || if_ready;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    imem_req   = 1'b0;
    load_slot  = 1'b0;
`ifdef FETCH_MISALIGN_ERR_EN
    load_err   = 1'b0;
`endif
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
`ifdef FETCH_MISALIGN_ERR_EN
        if (pc_reg[1:0] != 2'b00) begin
          if (slot_free && !redirect) begin
            load_err   = 1'b1;
            state_next = ERR;
          end
        end else
`endif
        begin
          imem_req = slot_free;
          if (imem_req && imem_ready)
            state_next = redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          load_slot  = !redirect;
          pc_next    = npc;
          state_next = FETCH;
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid)
          state_next = FETCH;
      end
      ERR: begin
        if (redirect)
          state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
    // A redirect always retargets the fetch path, whatever the state.
    if (redirect)
      pc_next = npc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      slot_valid_reg <= 1'b0;
      slot_pc_reg    <= 32'h0;
      slot_instr_reg <= 32'h0;
`ifdef FETCH_MISALIGN_ERR_EN
      slot_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (redirect) begin
        slot_valid_reg <= 1'b0;
      end else if (load_slot) begin
        slot_valid_reg <= 1'b1;
        slot_pc_reg    <= pc_reg;
        slot_instr_reg <= imem_rdata;
`ifdef FETCH_MISALIGN_ERR_EN
        slot_err_reg   <= 1'b0;
      end else if (load_err) begin
        slot_valid_reg <= 1'b1;
        slot_pc_reg    <= pc_reg;
        slot_instr_reg <= 32'h0;
        slot_err_reg   <= 1'b1;
`endif
      end else if (if_ready) begin
        slot_valid_reg <= 1'b0;
      end
    end
  end

  assign pc        = pc_reg;
  assign imem_addr = {pc_reg[31:2], 2'b00};
  assign if_valid  = slot_valid_reg;
  assign if_pc     = slot_pc_reg;
  assign if_instr  = slot_instr_reg;
`ifdef FETCH_MISALIGN_ERR_EN
  assign if_err    = slot_err_reg;
`else
  assign if_err    = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_3000, first fetch address after reset.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 npc  input  32  next PC from npc unit (pc+4 or jump/branch target).
REQ-005 redirect  input  1  taken jump/branch; npc is the new fetch path.
REQ-006 pc  output  32  current fetch PC, feeds npc unit.
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  32  word address of request.
REQ-009 imem_ready  input  1  request accepted this cycle.
REQ-010 imem_rvalid  input  1  instruction returned this cycle.
REQ-011 imem_rdata  input  32  returned instruction.
REQ-012 if_valid  output  1  IF/ID slot holds an instruction.
REQ-013 if_pc  output  32  PC of slot instruction.
REQ-014 if_instr  output  32  slot instruction.
REQ-015 if_err  output  1  slot entry is a misaligned-fetch fault.
REQ-016 if_ready  input  1  decode consumes slot this cycle.

Function
REQ-017 States IDLE, FETCH, WAIT, DROP, ERR; at most one imem request outstanding.
REQ-018 IDLE: imem_req=0; unconditionally to FETCH next cycle.
REQ-019 FETCH: imem_req = (!if_valid | if_ready); imem_addr = {pc[31:2],2'b00}; addr may change while imem_ready=0.
REQ-020 FETCH, imem_req & imem_ready: to WAIT, or DROP if redirect same edge.
REQ-021 WAIT, imem_rvalid & !redirect: slot <= {1, pc, imem_rdata, err=0}; pc <= npc; to FETCH.
REQ-022 WAIT, imem_rvalid & redirect: response discarded; pc <= npc; to FETCH.
REQ-023 WAIT, redirect & !imem_rvalid: pc <= npc; to DROP.
REQ-024 DROP: imem_req=0; imem_rvalid discards data, to FETCH; redirect in DROP updates pc <= npc, stays DROP.
REQ-025 Redirect in any state: pc <= npc, if_valid <= 0 same edge, regardless of if_ready (flush wins over consume).
REQ-026 Slot drains when if_valid & if_ready & !redirect; if_valid <= 0 unless refilled same edge.
REQ-027 Slot is only refilled in WAIT; a request is only accepted with slot empty or draining, so refill never overwrites a live entry.
REQ-028 imem_rvalid in IDLE/FETCH/ERR is a protocol error; ignored.
REQ-029 Minimum fetch period 2 cycles (accept, then response ≥1 cycle later); pc wrap 32'hFFFF_FFFC -> npc as supplied, no special case.

Reset
REQ-030 rst_n low, asynchronously: pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_pc=0, if_instr=0, if_err=0.
REQ-031 Reset mid-fetch abandons outstanding request; responses during reset ignored; first request RESET_PC two cycles after rst_n rises.

Configuration
REQ-032 Macro FETCH_MISALIGN_ERR_EN.
REQ-033 Defined: in FETCH with pc[1:0]!=0 and slot free, no imem_req; slot <= {1, pc, 32'h0, err=1}; to ERR; ERR holds (imem_req=0) until redirect, then pc <= npc, to FETCH.
REQ-034 Undefined: pc[1:0] ignored (imem_addr low bits forced 00), ERR unreachable, if_err tied 0.

Verification
REQ-035 Reset release, imem_ready=1, rvalid 1 cycle after accept, npc=pc+4, if_ready=1 -> imem_addr 3000,3004,3008; if_pc matches each, one instruction every 2 cycles.
REQ-036 if_ready=0 with slot full -> imem_req=0, slot/pc stable; raise if_ready -> imem_req same cycle.
REQ-037 redirect=1, npc=32'h0000_4000 while in WAIT -> if_valid 0 next edge; late response discarded; next imem_addr 4000.
REQ-038 imem_ready held 0 three cycles then redirect npc=32'h0000_5000 -> imem_addr switches to 5000 while still unaccepted; no DROP.
REQ-039 rst_n asserted in WAIT, rvalid arrives during reset -> all outputs reset values, no slot load; restart at 3000.
REQ-040 FETCH_MISALIGN_ERR_EN defined, redirect npc=32'h0000_4002 -> no imem_req, if_valid=1, if_err=1, if_pc=4002; redirect npc=4004 -> fetch resumes at 4004.
